// File: rtl/quad_encoder_pkg.sv
// quad_encoder_pkg: shared constants, types and helpers for the multi-channel quadrature encoder
package quad_encoder_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_IRQ_EN  = 2'd2;
    localparam logic [1:0] SUB_COUNT   = 2'd0;
    localparam logic [1:0] SUB_CAPTURE = 2'd1;
    localparam logic [1:0] SUB_CFG     = 2'd2;
    localparam int CFG_INV     = 8;
    localparam int CFG_IDX_EN  = 9;
    localparam int CFG_IDX_CLR = 10;
    localparam int ST_OVF = 0;
    localparam int ST_UNF = 8;
    localparam int ST_IDX = 16;
    localparam int ST_ERR = 24;

    typedef struct packed {
        logic idx_clr;
        logic idx_en;
        logic inv;
    } cfg_t;

    typedef struct packed {
        logic       ok;
        logic       glob;
        logic [1:0] sub;
        logic [2:0] ch;
    } addr_dec_t;

    // Gray position 00,01,11,10 -> 0,1,2,3 so a step is a modulo-4 difference
    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction
endpackage

// File: rtl/quad_encoder_channel.sv
// quad_encoder_channel: sync, glitch filter, x4 decode, position counter and index capture
module quad_encoder_channel
    import quad_encoder_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int FILT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a,
    input  logic                 b,
    input  logic                 i,
    input  logic                 en,
    input  logic [FILT_W-1:0]    filt,
    input  cfg_t                 cfg,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] capture,
    output logic                 ovf,
    output logic                 unf,
    output logic                 idx,
    output logic                 err
);
    logic [2:0] s1, s2, f;
    logic [FILT_W-1:0] fc [3];
    logic [1:0] prev_ab, d;
    logic prev_i, up, dn, hold;

    always_comb begin
        d = gray2bin(f[2:1]) - gray2bin(prev_ab);
        up = en & (cfg.inv ? d == 2'd3 : d == 2'd1);
        dn = en & (cfg.inv ? d == 2'd1 : d == 2'd3);
        idx = cfg.idx_en & f[0] & ~prev_i;
        err = d == 2'd2;
        hold = load | (idx & cfg.idx_clr);
        ovf = up & ~hold & (&count);
        unf = dn & ~hold & (count == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s1, s2, f, prev_ab, prev_i} <= '0;
            fc <= '{default: '0};
            count <= '0;
            capture <= '0;
        end else begin
            s1 <= {a, b, i};
            s2 <= s1;
            // each input must differ from its filtered value for filt+1 cycles running
            for (int k = 0; k < 3; k++) begin
                if (s2[k] == f[k]) fc[k] <= '0;
                else if (fc[k] == filt) begin
                    f[k] <= s2[k];
                    fc[k] <= '0;
                end else fc[k] <= fc[k] + 1'b1;
            end
            prev_ab <= f[2:1];
            prev_i <= f[0];
            if (idx) capture <= count;
            if (load) count <= load_value;
            else if (idx & cfg.idx_clr) count <= '0;
            else if (up) count <= count + 1'b1;
            else if (dn) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/quad_encoder_axil_multi.sv
// quad_encoder_axil_multi: multi-channel quadrature encoder with an AXI4-Lite register bank
module quad_encoder_axil_multi
    import quad_encoder_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int FILT_W     = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [NUM_CH-1:0]     enc_a,
    input  logic [NUM_CH-1:0]     enc_b,
    input  logic [NUM_CH-1:0]     enc_i,
    output logic                  irq,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);
    localparam logic [7:0]  CH_M     = 8'((1 << NUM_CH) - 1);
    localparam logic [31:0] CTRL_M   = 32'(CH_M);
    localparam logic [31:0] ST_M     = {4{CH_M}};
    localparam logic [31:0] CFG_M    = 32'((1 << FILT_W) - 1) | (32'd1 << CFG_INV) | (32'd1 << CFG_IDX_EN) | (32'd1 << CFG_IDX_CLR);

    logic [31:0] ctrl, status, irq_en, bm, rd, hw_set;
    logic [31:0] cfg_r [NUM_CH];
    logic [CNT_WIDTH-1:0] count [NUM_CH];
    logic [CNT_WIDTH-1:0] capture [NUM_CH];
    logic [NUM_CH-1:0] load, ovf, unf, idx, err;
    logic wen, ren, wr_glob, wr_ch;
    addr_dec_t dw, dr;

    // 16-byte blocks: block 0 holds global registers, block n holds channel n-1
    function automatic addr_dec_t decode(input logic [ADDR_WIDTH-1:0] a);
        addr_dec_t r;
        logic [ADDR_WIDTH-5:0] blk;
        blk = a[ADDR_WIDTH-1:4];
        r.glob = blk == '0;
        r.sub = a[3:2];
        r.ch = 3'(blk - 1'b1);
        r.ok = a[1:0] == 2'b00 && blk <= (ADDR_WIDTH-4)'(NUM_CH);
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [31:0] m);
        return (old & ~m) | (nw & m);
    endfunction

    assign dw = decode(S_AXI_AWADDR);
    assign dr = decode(S_AXI_ARADDR);
    assign wen = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID;
    assign ren = S_AXI_ARVALID & ~S_AXI_RVALID;
    assign S_AXI_AWREADY = wen;
    assign S_AXI_WREADY = wen;
    assign S_AXI_ARREADY = ren;
    assign wr_glob = wen & dw.ok & dw.glob;
    assign wr_ch = wen & dw.ok & ~dw.glob;
    assign bm = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
    assign hw_set = (32'(ovf) << ST_OVF) | (32'(unf) << ST_UNF) | (32'(idx) << ST_IDX) | (32'(err) << ST_ERR);
    assign irq = |(status & irq_en);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [31:0] lv;
        assign load[g] = wr_ch && dw.ch == 3'(g) && dw.sub == SUB_COUNT;
        assign lv = merge(32'(count[g]), S_AXI_WDATA, bm);
        quad_encoder_channel #(.CNT_WIDTH(CNT_WIDTH), .FILT_W(FILT_W)) u_ch (
            .clk(ACLK), .rst(ARESET), .a(enc_a[g]), .b(enc_b[g]), .i(enc_i[g]),
            .en(ctrl[g]), .filt(cfg_r[g][FILT_W-1:0]), .cfg(cfg_t'(cfg_r[g][CFG_IDX_CLR:CFG_INV])),
            .load(load[g]), .load_value(lv[CNT_WIDTH-1:0]), .count(count[g]), .capture(capture[g]),
            .ovf(ovf[g]), .unf(unf[g]), .idx(idx[g]), .err(err[g])
        );
    end

    always_comb begin
        rd = '0;
        if (dr.glob) rd = dr.sub == REG_CTRL ? ctrl : dr.sub == REG_STATUS ? status : dr.sub == REG_IRQ_EN ? irq_en : '0;
        for (int c = 0; c < NUM_CH; c++)
            if (!dr.glob && dr.ch == 3'(c))
                rd = dr.sub == SUB_COUNT ? 32'(count[c]) : dr.sub == SUB_CAPTURE ? 32'(capture[c]) : dr.sub == SUB_CFG ? cfg_r[c] : '0;
        if (!dr.ok) rd = '0;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP <= RESP_OKAY;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
            ctrl <= '0;
            status <= '0;
            irq_en <= '0;
            for (int c = 0; c < NUM_CH; c++) cfg_r[c] <= '0;
        end else begin
            S_AXI_BVALID <= wen | (S_AXI_BVALID & ~S_AXI_BREADY);
            if (wen) S_AXI_BRESP <= dw.ok ? RESP_OKAY : RESP_SLVERR;
            S_AXI_RVALID <= ren | (S_AXI_RVALID & ~S_AXI_RREADY);
            if (ren) begin
                S_AXI_RDATA <= rd;
                S_AXI_RRESP <= dr.ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (wr_glob && dw.sub == REG_CTRL) ctrl <= merge(ctrl, S_AXI_WDATA, bm) & CTRL_M;
            if (wr_glob && dw.sub == REG_IRQ_EN) irq_en <= merge(irq_en, S_AXI_WDATA, bm) & ST_M;
            // hardware sets are OR-ed after the clear so a same-cycle event survives
            status <= (status & ~(wr_glob && dw.sub == REG_STATUS ? S_AXI_WDATA & bm : '0)) | hw_set;
            for (int c = 0; c < NUM_CH; c++)
                if (wr_ch && dw.ch == 3'(c) && dw.sub == SUB_CFG) cfg_r[c] <= merge(cfg_r[c], S_AXI_WDATA, bm) & CFG_M;
        end
    end
endmodule

// File: tb/tb_quad_encoder_axil_multi.sv
// tb_quad_encoder_axil_multi: directed self-checking bench for quad_encoder_axil_multi
module tb_quad_encoder_axil_multi;
    logic ACLK = 0, ARESET = 1;
    logic [3:0] enc_a = 0, enc_b = 0, enc_i = 0;
    logic irq;
    logic [7:0] S_AXI_AWADDR = 0, S_AXI_ARADDR = 0;
    logic S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0, S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [31:0] S_AXI_WDATA = 0;
    logic [3:0] S_AXI_WSTRB = 0;
    logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    int passes = 0, total = 0;

    quad_encoder_axil_multi dut (
        .ACLK(ACLK), .ARESET(ARESET), .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i), .irq(irq),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic set_ab(input logic a, input logic b, input int hold);
        enc_a[0] = a;
        enc_b[0] = b;
        wait_cyc(hold);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        S_AXI_ARADDR = addr;
        S_AXI_ARVALID = 1;
        S_AXI_RREADY = 1;
        #1;
        while (!S_AXI_ARREADY && n < 50) begin
            wait_cyc(1);
            n++;
        end
        if (n >= 50) begin
            total++;
            $error("FAIL ar_timeout: addr %h never accepted", addr);
        end
        @(posedge ACLK);
        #1;
        S_AXI_ARVALID = 0;
        chk("rvalid", S_AXI_RVALID, 1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        wait_cyc(1);
        S_AXI_RREADY = 0;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb, output logic [1:0] resp);
        int n = 0;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA = data;
        S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1;
        S_AXI_WVALID = 1;
        #1;
        while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50) begin
            wait_cyc(1);
            n++;
        end
        if (n >= 50) begin
            total++;
            $error("FAIL aw_timeout: addr %h never accepted", addr);
        end
        @(posedge ACLK);
        #1;
        S_AXI_AWVALID = 0;
        S_AXI_WVALID = 0;
        chk("bvalid", S_AXI_BVALID, 1);
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1;
        wait_cyc(1);
        S_AXI_BREADY = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0] r;
        axi_read(addr, d, r);
        chk(tag, {r, d}, {exp_resp, exp});
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb, input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_write(addr, data, strb, r);
        chk(tag, r, exp_resp);
    endtask

    initial begin
        wait_cyc(3);
        chk("reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, irq,
                              S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 0);
        ARESET = 0;
        wait_cyc(2);

        // register bank comes up empty
        for (int k = 0; k < 8; k++) rd_chk("reset_reg", 8'(4 * k), 0, 2'b00);
        rd_chk("ch4_slverr", 8'h50, 0, 2'b10);

        // forward then reverse quadrature on channel 0
        wr_chk("ctrl_all", 8'h00, 32'hFFFF_FFFF, 4'hF, 2'b00);
        rd_chk("ctrl_mask", 8'h00, 32'h0000_000F, 2'b00);
        wr_chk("ctrl_en0", 8'h00, 32'h1, 4'hF, 2'b00);
        set_ab(0, 1, 10); set_ab(1, 1, 10); set_ab(1, 0, 10); set_ab(0, 0, 10);
        rd_chk("count_fwd", 8'h10, 32'd4, 2'b00);
        for (int k = 0; k < 2; k++) begin
            set_ab(1, 0, 10); set_ab(1, 1, 10); set_ab(0, 1, 10); set_ab(0, 0, 10);
        end
        rd_chk("count_rev", 8'h10, 32'hFFFF_FFFC, 2'b00);
        rd_chk("status_unf", 8'h04, 32'h0000_0100, 2'b00);
        chk("irq_masked", irq, 0);

        // interrupt enable and byte-strobed W1C
        wr_chk("irq_en", 8'h08, 32'h100, 4'hF, 2'b00);
        chk("irq_on", irq, 1);
        wr_chk("w1c_wrong_byte", 8'h04, 32'h100, 4'b0001, 2'b00);
        chk("irq_still_on", irq, 1);
        wr_chk("w1c", 8'h04, 32'h100, 4'b0010, 2'b00);
        chk("irq_off", irq, 0);
        rd_chk("status_clear", 8'h04, 0, 2'b00);

        // glitch filter with FILT=3 needs 4 stable cycles
        wr_chk("cfg_filt", 8'h18, 32'h3, 4'hF, 2'b00);
        set_ab(1, 0, 2); set_ab(0, 0, 12);
        rd_chk("glitch2", 8'h10, 32'hFFFF_FFFC, 2'b00);
        set_ab(1, 0, 3); set_ab(0, 0, 12);
        rd_chk("glitch3", 8'h10, 32'hFFFF_FFFC, 2'b00);
        set_ab(0, 1, 5); wait_cyc(8);
        rd_chk("hold5", 8'h10, 32'hFFFF_FFFD, 2'b00);
        rd_chk("status_quiet", 8'h04, 0, 2'b00);

        // index capture and clear
        wr_chk("cfg_idx", 8'h18, 32'h603, 4'hF, 2'b00);
        wr_chk("count_load", 8'h10, 32'h1234, 4'hF, 2'b00);
        enc_i[0] = 1; wait_cyc(6); enc_i[0] = 0; wait_cyc(12);
        rd_chk("capture", 8'h14, 32'h1234, 2'b00);
        rd_chk("count_idx_clr", 8'h10, 0, 2'b00);
        rd_chk("status_idx", 8'h04, 32'h0001_0000, 2'b00);
        chk("irq_idx_masked", irq, 0);

        // strobed count load, read-only and unmapped writes
        wr_chk("count_strb", 8'h10, 32'hAABB_CCDD, 4'b0011, 2'b00);
        rd_chk("count_strb_rd", 8'h10, 32'h0000_CCDD, 2'b00);
        wr_chk("capture_wr", 8'h14, 32'hFFFF, 4'hF, 2'b00);
        rd_chk("capture_kept", 8'h14, 32'h1234, 2'b00);
        wr_chk("wr_slverr", 8'h50, 32'h1, 4'hF, 2'b10);
        wr_chk("wr_rsvd", 8'h0C, 32'h1, 4'hF, 2'b00);
        rd_chk("rsvd_rd", 8'h0C, 0, 2'b00);

        // illegal two-bit transition
        set_ab(0, 0, 12);
        rd_chk("count_dec", 8'h10, 32'h0000_CCDC, 2'b00);
        set_ab(1, 1, 12);
        rd_chk("count_err", 8'h10, 32'h0000_CCDC, 2'b00);
        rd_chk("status_err", 8'h04, 32'h0101_0000, 2'b00);

        // overflow wrap, then inverted direction with underflow
        wr_chk("count_max", 8'h10, 32'hFFFF_FFFF, 4'hF, 2'b00);
        set_ab(1, 0, 12);
        rd_chk("count_ovf", 8'h10, 0, 2'b00);
        rd_chk("status_ovf", 8'h04, 32'h0101_0001, 2'b00);
        wr_chk("cfg_all", 8'h18, 32'hFFFF_FFFF, 4'hF, 2'b00);
        rd_chk("cfg_mask", 8'h18, 32'h0000_070F, 2'b00);
        wr_chk("cfg_inv", 8'h18, 32'h103, 4'hF, 2'b00);
        set_ab(0, 0, 12);
        rd_chk("count_inv", 8'h10, 32'hFFFF_FFFF, 2'b00);
        rd_chk("status_inv", 8'h04, 32'h0101_0101, 2'b00);
        chk("irq_unf", irq, 1);
        wr_chk("irq_en_off", 8'h08, 0, 4'hF, 2'b00);
        chk("irq_dis", irq, 0);

        // AW waits for W; B held off blocks a second write
        S_AXI_AWADDR = 8'h00; S_AXI_WDATA = 32'h3; S_AXI_WSTRB = 4'hF; S_AXI_AWVALID = 1;
        for (int k = 0; k < 3; k++) begin
            wait_cyc(1);
            chk("aw_alone", {S_AXI_AWREADY, S_AXI_WREADY}, 0);
        end
        S_AXI_WVALID = 1;
        #1;
        chk("aw_w_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        @(posedge ACLK);
        #1;
        S_AXI_AWADDR = 8'h08; S_AXI_WDATA = 32'h0100_0000;
        for (int k = 0; k < 5; k++) begin
            chk("bvalid_hold", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b10);
            wait_cyc(1);
        end
        S_AXI_BREADY = 1;
        wait_cyc(1);
        chk("bvalid_drop", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b01);
        wait_cyc(1);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        chk("second_b", {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
        wait_cyc(1);
        S_AXI_BREADY = 0;
        chk("irq_err", irq, 1);
        rd_chk("ctrl_second", 8'h00, 32'h3, 2'b00);

        // reset during a pending read response
        S_AXI_ARADDR = 8'h10; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
        #1;
        chk("arready", S_AXI_ARREADY, 1);
        @(posedge ACLK);
        #1;
        S_AXI_ARVALID = 0;
        chk("rvalid_pending", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, 32'hFFFF_FFFF});
        #2 ARESET = 1;
        #1;
        chk("reset_abort", {S_AXI_RVALID, S_AXI_BVALID, irq, S_AXI_RDATA}, 0);
        wait_cyc(2);
        ARESET = 0;
        wait_cyc(1);
        rd_chk("ctrl_after_rst", 8'h00, 0, 2'b00);
        rd_chk("count_after_rst", 8'h10, 0, 2'b00);
        rd_chk("status_after_rst", 8'h04, 0, 2'b00);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
